framed_stream_parser: RTL

FRAMED_STREAM_PARSER -- requirements
Module: framed_stream_parser

---
 rtl/framed_stream_parser_if.sv | 17 +
 rtl/framed_stream_parser.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/framed_stream_parser_if.sv
// Byte-lane stream bundle used on both sides of the framed stream parser.
// Handshake: a beat moves on a rising clk edge only when tvalid and tready
// are both 1; the master holds every payload signal stable while tvalid=1
// and tready=0, and tready may depend combinationally on the other side.
interface framed_stream_parser_if #(
    parameter int DATA_BYTES = 4
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic                    tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/framed_stream_parser.sv
// Framed stream parser: finds a lane-0 sync word, forwards LEN payload bytes
// in their original lanes, checks a trailing XOR checksum and flags errors
// on the last output beat through tuser. Keeps saturating frame statistics.
module framed_stream_parser #(
    parameter int          DATA_BYTES = 4,
    parameter int          MAX_LEN    = 255,
    parameter logic [15:0] SYNC_WORD  = 16'h55AA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    framed_stream_parser_if.slave  s_axis,
    framed_stream_parser_if.master m_axis,
    output logic [15:0]            frame_count,
    output logic [15:0]            crc_err_count,
    output logic [15:0]            len_err_count
);
    localparam int         W    = 8 * DATA_BYTES;
    localparam logic [8:0] NB   = 9'(DATA_BYTES);
    localparam logic [8:0] MAXL = 9'(MAX_LEN);

    typedef enum logic [1:0] {SEARCH, PAYLOAD, CHECK} state_t;
    state_t state, state_nxt;

    logic [7:0]            remaining, remaining_nxt;
    logic [7:0]            xor_acc, xor_acc_nxt;
    logic                  hold_pending, hold_pending_nxt;
    logic [W-1:0]          tdata_q, tdata_nxt;
    logic [DATA_BYTES-1:0] tkeep_q, tkeep_nxt;
    logic                  tvalid_q, tvalid_nxt;
    logic                  tlast_q, tlast_nxt;
    logic                  tuser_q, tuser_nxt;
    logic                  len_err_evt;

    logic                  out_free, in_xfer, sync_hit, out_last_xfer;
    logic [7:0]            lane [DATA_BYTES];
    logic [8:0]            len9, first_lane, pay_cnt, ck_lane;
    logic [7:0]            beat_xor, ck_byte;
    logic [W-1:0]          beat_data;
    logic [DATA_BYTES-1:0] beat_keep;

    // Sideband inputs of the incoming stream carry no meaning for parsing.
    wire unused_in_side = ^{s_axis.tkeep, s_axis.tlast, s_axis.tuser};

    // A held beat sits in the output register with valid low, so the
    // register counts as free and the checksum beat can still be accepted.
    assign out_free      = !tvalid_q || m_axis.tready;
    assign s_axis.tready = out_free;
    assign in_xfer       = s_axis.tvalid && out_free;
    assign out_last_xfer = tvalid_q && m_axis.tready && tlast_q;

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tuser  = tuser_q;

    // Split the input beat into byte lanes.
    always_comb begin
        for (int k = 0; k < DATA_BYTES; k++) lane[k] = s_axis.tdata[8*k +: 8];
    end

    assign sync_hit = (lane[0] == SYNC_WORD[7:0]) && (lane[1] == SYNC_WORD[15:8]);
    assign len9     = {1'b0, lane[2]};

    // Locate payload lanes and the checksum lane of the current beat.
    always_comb begin
        first_lane = 9'd0;
        pay_cnt    = 9'd0;
        if (state == SEARCH) begin
            first_lane = 9'd3;
            pay_cnt    = (len9 < NB - 9'd3) ? len9 : NB - 9'd3;
        end else if (state == PAYLOAD) begin
            pay_cnt = ({1'b0, remaining} < NB) ? {1'b0, remaining} : NB;
        end
        ck_lane   = first_lane + pay_cnt;
        beat_xor  = 8'd0;
        ck_byte   = 8'd0;
        beat_data = '0;
        beat_keep = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (9'(k) >= first_lane && 9'(k) < ck_lane) begin
                beat_keep[k]        = 1'b1;
                beat_data[8*k +: 8] = lane[k];
                beat_xor            = beat_xor ^ lane[k];
            end
            if (9'(k) == ck_lane) ck_byte = lane[k];
        end
    end

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_nxt        = state;
        remaining_nxt    = remaining;
        xor_acc_nxt      = xor_acc;
        hold_pending_nxt = hold_pending;
        tdata_nxt        = tdata_q;
        tkeep_nxt        = tkeep_q;
        tvalid_nxt       = tvalid_q;
        tlast_nxt        = tlast_q;
        tuser_nxt        = tuser_q;
        len_err_evt      = 1'b0;
        if (in_xfer) begin
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            tuser_nxt  = 1'b0;
            case (state)
                SEARCH: begin
                    if (sync_hit) begin
                        if (lane[2] == 8'd0 || len9 > MAXL) begin
                            len_err_evt = 1'b1;
                        end else begin
                            tdata_nxt = beat_data;
                            tkeep_nxt = beat_keep;
                            if (len9 < NB - 9'd3) begin
                                tvalid_nxt = 1'b1;
                                tlast_nxt  = 1'b1;
                                tuser_nxt  = (ck_byte != beat_xor);
                            end else if (len9 == NB - 9'd3) begin
                                hold_pending_nxt = 1'b1;
                                xor_acc_nxt      = beat_xor;
                                state_nxt        = CHECK;
                            end else begin
                                tvalid_nxt    = 1'b1;
                                remaining_nxt = lane[2] - 8'(NB - 9'd3);
                                xor_acc_nxt   = beat_xor;
                                state_nxt     = PAYLOAD;
                            end
                        end
                    end
                end
                PAYLOAD: begin
                    tdata_nxt   = beat_data;
                    tkeep_nxt   = beat_keep;
                    xor_acc_nxt = xor_acc ^ beat_xor;
                    if ({1'b0, remaining} < NB) begin
                        tvalid_nxt    = 1'b1;
                        tlast_nxt     = 1'b1;
                        tuser_nxt     = (ck_byte != (xor_acc ^ beat_xor));
                        remaining_nxt = 8'd0;
                        state_nxt     = SEARCH;
                    end else if ({1'b0, remaining} == NB) begin
                        hold_pending_nxt = 1'b1;
                        remaining_nxt    = 8'd0;
                        state_nxt        = CHECK;
                    end else begin
                        tvalid_nxt    = 1'b1;
                        remaining_nxt = remaining - 8'(NB);
                    end
                end
                CHECK: begin
                    tvalid_nxt       = 1'b1;
                    tlast_nxt        = 1'b1;
                    tuser_nxt        = (ck_byte != xor_acc);
                    hold_pending_nxt = 1'b0;
                    state_nxt        = SEARCH;
                end
                default: state_nxt = SEARCH;
            endcase
        end else if (out_free && !hold_pending) begin
            tvalid_nxt = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SEARCH;
        else        state <= state_nxt;
    end

    // Frame bookkeeping and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining    <= 8'd0;
            xor_acc      <= 8'd0;
            hold_pending <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
        end else begin
            remaining    <= remaining_nxt;
            xor_acc      <= xor_acc_nxt;
            hold_pending <= hold_pending_nxt;
            tdata_q      <= tdata_nxt;
            tkeep_q      <= tkeep_nxt;
            tvalid_q     <= tvalid_nxt;
            tlast_q      <= tlast_nxt;
            tuser_q      <= tuser_nxt;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count   <= 16'd0;
            crc_err_count <= 16'd0;
            len_err_count <= 16'd0;
        end else begin
            if (out_last_xfer && frame_count != 16'hFFFF)
                frame_count <= frame_count + 16'd1;
            if (out_last_xfer && tuser_q && crc_err_count != 16'hFFFF)
                crc_err_count <= crc_err_count + 16'd1;
            if (len_err_evt && len_err_count != 16'hFFFF)
                len_err_count <= len_err_count + 16'd1;
        end
    end
endmodule
